// File: rtl/countdown_ctrl.sv
// countdown_ctrl: set/run/pause/expire sequencer for the countdown-timer game.
// Holds MM:SS in BCD, decrements once per prescaled second and requests
// display blanking while expired. All outputs come straight from flops.
//
// Inputs start_p/up_p/down_p are single-cycle pulses from the debouncers.
// They are sampled on the rising edge of Clk100Mhz. In any one cycle the
// priority is start_p > up_p > down_p. up_p and down_p together, without
// start_p, cancel each other.
module countdown_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic       Clk100Mhz,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       up_p,
  input  logic       down_p,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       expired,
  output logic       blank,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    ST_SET     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);

  state_t        stateQ, stateD;
  logic [15:0]   cntQ, cntD;        // {m10, m1, s10, s1}
  logic [15:0]   presetQ, presetD;
  logic [PW-1:0] preQ, preD;
  logic [FW-1:0] flashQ, flashD;
  logic          blankQ, blankD;
  logic          runningQ, expiredQ;
  logic [15:0]   cntDec;

  // +1 second in BCD, saturating at 99:59
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [3:0] a, b, c, d;
    {a, b, c, d} = v;
    if (v == 16'h9959) return v;
    if (d != 4'd9) d = d + 4'd1;
    else begin
      d = 4'd0;
      if (c != 4'd5) c = c + 4'd1;
      else begin
        c = 4'd0;
        if (b != 4'd9) b = b + 4'd1;
        else begin
          b = 4'd0;
          a = a + 4'd1;
        end
      end
    end
    return {a, b, c, d};
  endfunction

  // -1 second in BCD, saturating at 00:00
  function automatic logic [15:0] bcdDec(input logic [15:0] v);
    logic [3:0] a, b, c, d;
    {a, b, c, d} = v;
    if (v == 16'h0000) return v;
    if (d != 4'd0) d = d - 4'd1;
    else begin
      d = 4'd9;
      if (c != 4'd0) c = c - 4'd1;
      else begin
        c = 4'd5;
        if (b != 4'd0) b = b - 4'd1;
        else begin
          b = 4'd9;
          a = a - 4'd1;
        end
      end
    end
    return {a, b, c, d};
  endfunction

  assign cntDec = bcdDec(cntQ);

  // Next-state and datapath updates; every value holds unless a case changes it
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    presetD = presetQ;
    preD    = preQ;
    flashD  = flashQ;
    blankD  = blankQ;
    unique case (stateQ)
      ST_SET: begin
        if (start_p) begin
          if (cntQ != 16'h0000) begin
            presetD = cntQ;
            preD    = '0;
            stateD  = ST_RUN;
          end
        end else if (up_p && !down_p) begin
          cntD = bcdInc(cntQ);
        end else if (down_p && !up_p) begin
          cntD = cntDec;
        end
      end
      ST_RUN: begin
        // The pausing cycle still counts as run time, so a tick that
        // coincides with start_p is applied before the pause takes hold.
        if (preQ == PRE_MAX) begin
          preD = '0;
          cntD = cntDec;
          if (cntDec == 16'h0000) begin
            stateD = ST_EXPIRED;
            flashD = '0;
            blankD = 1'b0;
          end else if (start_p) begin
            stateD = ST_PAUSE;
          end
        end else begin
          preD = preQ + 1'b1;
          if (start_p) stateD = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_p) stateD = ST_RUN;
      end
      ST_EXPIRED: begin
        if (start_p) begin
          cntD   = presetQ;
          blankD = 1'b0;
          flashD = '0;
          stateD = ST_SET;
        end else if (flashQ == FLASH_MAX) begin
          flashD = '0;
          blankD = ~blankQ;
        end else begin
          flashD = flashQ + 1'b1;
        end
      end
      default: stateD = ST_SET;
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge Clk100Mhz) begin
    if (!rst_n) begin
      stateQ   <= ST_SET;
      cntQ     <= 16'h0000;
      presetQ  <= 16'h0000;
      preQ     <= '0;
      flashQ   <= '0;
      blankQ   <= 1'b0;
      runningQ <= 1'b0;
      expiredQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      presetQ  <= presetD;
      preQ     <= preD;
      flashQ   <= flashD;
      blankQ   <= blankD;
      runningQ <= (stateD == ST_RUN);
      expiredQ <= (stateD == ST_EXPIRED);
    end
  end

  assign {m10, m1, s10, s1} = cntQ;
  assign running  = runningQ;
  assign expired  = expiredQ;
  assign blank    = blankQ;
  assign dbgState = stateQ;

endmodule
